// File: rtl/alu_op_sequencer.sv
// Issue sequencer for RV32I OP / OP-IMM instructions.
// Accepts one instruction at a time, reads operands from the register file,
// drives the FunctionUnit with A/B/FS, captures S and writes it back.
// The sequence is IDLE -> READ -> EXEC -> WB, or IDLE -> ERR for rejected words.
module alu_op_sequencer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  output logic [REG_AW-1:0] rf_raddr1,
  output logic [REG_AW-1:0] rf_raddr2,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  output logic [DATA_W-1:0] fu_a,
  output logic [DATA_W-1:0] fu_b,
  output logic [3:0]        fu_fs,
  input  logic [DATA_W-1:0] fu_s,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              done,
  output logic              illegal
);

  localparam logic [6:0] OpcOp    = 7'b0110011;
  localparam logic [6:0] OpcOpImm = 7'b0010011;
  localparam logic [6:0] F7Zero   = 7'b0000000;
  localparam logic [6:0] F7Alt    = 7'b0100000;

  typedef enum logic [2:0] {StIdle, StRead, StExec, StWb, StErr} state_e;

  state_e              state_q, state_d;
  logic [31:0]         instr_q, instr_d;
  logic [REG_AW-1:0]   raddr1_q, raddr1_d;
  logic [REG_AW-1:0]   raddr2_q, raddr2_d;
  logic [DATA_W-1:0]   fu_a_q, fu_a_d;
  logic [DATA_W-1:0]   fu_b_q, fu_b_d;
  logic [3:0]          fu_fs_q, fu_fs_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [REG_AW-1:0]   waddr_q, waddr_d;
  logic                we_q, we_d;
  logic                done_q, done_d;
  logic                illegal_q, illegal_d;
  logic                ready_q, ready_d;

  logic                dec_legal;
  logic                lat_is_imm;
  logic                lat_b0;
  logic [DATA_W-1:0]   lat_imm;

  // Legality check of the incoming word, evaluated while IDLE.
  always_comb begin
    dec_legal = 1'b0;
    if (instr[6:0] == OpcOp) begin
      dec_legal = (instr[31:25] == F7Zero) ||
                  ((instr[31:25] == F7Alt) &&
                   ((instr[14:12] == 3'b000) || (instr[14:12] == 3'b101)));
    end else if (instr[6:0] == OpcOpImm) begin
      unique case (instr[14:12])
        3'b001:  dec_legal = (instr[31:25] == F7Zero);
        3'b101:  dec_legal = (instr[31:25] == F7Zero) || (instr[31:25] == F7Alt);
        default: dec_legal = 1'b1;
      endcase
    end
  end

  // Operand/FS derivation from the latched instruction, consumed in READ.
  always_comb begin
    lat_is_imm = (instr_q[6:0] == OpcOpImm);
    lat_imm    = {{(DATA_W-12){instr_q[31]}}, instr_q[31:20]};
    // OP-IMM has no SUBI, so only the shift-right group takes instr[30].
    if (lat_is_imm) begin
      lat_b0 = (instr_q[14:12] == 3'b101) ? instr_q[30] : 1'b0;
    end else begin
      lat_b0 = instr_q[30];
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    raddr1_d  = raddr1_q;
    raddr2_d  = raddr2_q;
    fu_a_d    = fu_a_q;
    fu_b_d    = fu_b_q;
    fu_fs_d   = fu_fs_q;
    result_d  = result_q;
    waddr_d   = waddr_q;

    unique case (state_q)
      StIdle: begin
        if (instr_valid) begin
          instr_d = instr;
          if (dec_legal) begin
            state_d  = StRead;
            raddr1_d = instr[19:15];
            raddr2_d = instr[24:20];
          end else begin
            state_d = StErr;
          end
        end
      end
      StRead: begin
        fu_a_d  = rf_rdata1;
        fu_b_d  = lat_is_imm ? lat_imm : rf_rdata2;
        fu_fs_d = {instr_q[14:12], lat_b0};
        state_d = StExec;
      end
      StExec: begin
        result_d = fu_s;
        waddr_d  = instr_q[11:7];
        state_d  = StWb;
      end
      StWb:    state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Strobes are registered against the next state so they align with it.
    ready_d   = (state_d == StIdle);
    we_d      = (state_d == StWb) && (instr_q[11:7] != 5'd0);
    done_d    = (state_d == StWb);
    illegal_d = (state_d == StErr);
  end

  // State and output registers; reset abandons any instruction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      instr_q   <= '0;
      raddr1_q  <= '0;
      raddr2_q  <= '0;
      fu_a_q    <= '0;
      fu_b_q    <= '0;
      fu_fs_q   <= '0;
      result_q  <= '0;
      waddr_q   <= '0;
      we_q      <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      raddr1_q  <= raddr1_d;
      raddr2_q  <= raddr2_d;
      fu_a_q    <= fu_a_d;
      fu_b_q    <= fu_b_d;
      fu_fs_q   <= fu_fs_d;
      result_q  <= result_d;
      waddr_q   <= waddr_d;
      we_q      <= we_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      ready_q   <= ready_d;
    end
  end

  assign instr_ready = ready_q;
  assign rf_raddr1   = raddr1_q;
  assign rf_raddr2   = raddr2_q;
  assign fu_a        = fu_a_q;
  assign fu_b        = fu_b_q;
  assign fu_fs       = fu_fs_q;
  assign rf_we       = we_q;
  assign rf_waddr    = waddr_q;
  assign rf_wdata    = result_q;
  assign done        = done_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: the bench acts as register file and
// FunctionUnit, and predicts every instruction's outcome from RV32I semantics.
module tb_alu_op_sequencer;

  logic        clk;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [4:0]  rf_raddr1;
  logic [4:0]  rf_raddr2;
  logic [31:0] rf_rdata1;
  logic [31:0] rf_rdata2;
  logic [31:0] fu_a;
  logic [31:0] fu_b;
  logic [3:0]  fu_fs;
  logic [31:0] fu_s;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        done;
  logic        illegal;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [31:0] reg_m [32];

  alu_op_sequencer #(.DATA_W(32), .REG_AW(5)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .rf_raddr1   (rf_raddr1),
    .rf_raddr2   (rf_raddr2),
    .rf_rdata1   (rf_rdata1),
    .rf_rdata2   (rf_rdata2),
    .fu_a        (fu_a),
    .fu_b        (fu_b),
    .fu_fs       (fu_fs),
    .fu_s        (fu_s),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .done        (done),
    .illegal     (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Register file: combinational reads from the model array.
  assign rf_rdata1 = reg_m[rf_raddr1];
  assign rf_rdata2 = reg_m[rf_raddr2];

  // FunctionUnit: FS code table.
  always_comb begin
    case (fu_fs)
      4'b0000: fu_s = fu_a + fu_b;
      4'b0001: fu_s = fu_a - fu_b;
      4'b0010: fu_s = fu_a << fu_b[4:0];
      4'b0100: fu_s = {31'd0, $signed(fu_a) < $signed(fu_b)};
      4'b0110: fu_s = {31'd0, fu_a < fu_b};
      4'b1000: fu_s = fu_a ^ fu_b;
      4'b1010: fu_s = fu_a >> fu_b[4:0];
      4'b1011: fu_s = $signed(fu_a) >>> fu_b[4:0];
      4'b1100: fu_s = fu_a | fu_b;
      4'b1110: fu_s = fu_a & fu_b;
      default: fu_s = 32'hDEAD_BEEF;
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic bit ref_legal(input logic [31:0] ins);
    logic [6:0] f7;
    logic [2:0] f3;
    f7 = ins[31:25];
    f3 = ins[14:12];
    if (ins[6:0] == 7'h33) return (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
    if (ins[6:0] == 7'h13) begin
      if (f3 == 3'd1) return f7 == 7'h00;
      if (f3 == 3'd5) return (f7 == 7'h00) || (f7 == 7'h20);
      return 1'b1;
    end
    return 1'b0;
  endfunction

  // RV32I result of an ALU operation, by mnemonic meaning.
  function automatic logic [31:0] rv_op(input logic [2:0] f3, input bit alt,
                                        input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0: return alt ? a - b : a + b;
      3'd1: return a << b[4:0];
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  // Issue one instruction at an IDLE negedge and check every phase of it.
  // Junk stays on instr with valid high while busy; it must be ignored.
  task automatic run_instr(input logic [31:0] ins);
    bit          is_imm;
    bit          alt;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    is_imm = (ins[6:0] == 7'h13);
    rd     = ins[11:7];
    rs1    = ins[19:15];
    rs2    = ins[24:20];
    a      = reg_m[rs1];
    b      = is_imm ? {{20{ins[31]}}, ins[31:20]} : reg_m[rs2];
    alt    = is_imm ? (ins[14:12] == 3'd5 && ins[30]) : ins[30];
    res    = rv_op(ins[14:12], alt, a, b);

    check_eq("ready_idle", instr_ready, 1);
    instr_valid = 1'b1;
    instr       = ins;
    @(negedge clk);
    instr = $urandom;
    if (!ref_legal(ins)) begin
      check_eq("err_illegal", illegal, 1);
      check_eq("err_we", rf_we, 0);
      check_eq("err_done", done, 0);
      check_eq("err_ready", instr_ready, 0);
      @(negedge clk);
      instr_valid = 1'b0;
      check_eq("post_err_illegal", illegal, 0);
      check_eq("post_err_ready", instr_ready, 1);
      return;
    end
    check_eq("read_ready", instr_ready, 0);
    check_eq("read_raddr1", rf_raddr1, rs1);
    check_eq("read_raddr2", rf_raddr2, rs2);
    check_eq("read_illegal", illegal, 0);
    @(negedge clk);
    instr = $urandom;
    check_eq("exec_fs", fu_fs, {ins[14:12], alt});
    check_eq("exec_a", fu_a, a);
    check_eq("exec_b", fu_b, b);
    check_eq("exec_done", done, 0);
    @(negedge clk);
    check_eq("wb_done", done, 1);
    check_eq("wb_we", rf_we, (rd != 5'd0));
    check_eq("wb_ready", instr_ready, 0);
    if (rd != 5'd0) begin
      check_eq("wb_waddr", rf_waddr, rd);
      check_eq("wb_wdata", rf_wdata, res);
      reg_m[rd] = res;
    end
    @(negedge clk);
    instr_valid = 1'b0;
    check_eq("post_wb_done", done, 0);
    check_eq("post_wb_we", rf_we, 0);
    check_eq("post_wb_ready", instr_ready, 1);
  endtask

  logic [31:0] rnd_ins;
  logic [6:0]  rnd_f7;

  initial begin
    rst         = 1'b1;
    instr_valid = 1'b0;
    instr       = '0;
    for (int i = 0; i < 32; i++) reg_m[i] = (i == 0) ? 32'd0 : $urandom;
    reg_m[1] = 32'd5;
    reg_m[2] = 32'd7;

    @(negedge clk);
    @(negedge clk);
    check_eq("rst_ready", instr_ready, 1);
    check_eq("rst_we", rf_we, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_illegal", illegal, 0);
    check_eq("rst_fs", fu_fs, 0);
    check_eq("rst_a", fu_a, 0);
    check_eq("rst_wdata", rf_wdata, 0);
    rst = 1'b0;
    @(negedge clk);

    // ADD in flight, reset asserted during EXEC.
    instr_valid = 1'b1;
    instr       = r_type(7'h00, 5'd2, 5'd1, 3'd0, 5'd3);
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    check_eq("mid_exec_fs", fu_fs, 4'b0000);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_eq("rst_hold_we", rf_we, 0);
    end
    rst = 1'b0;
    @(negedge clk);
    check_eq("rel_ready", instr_ready, 1);
    check_eq("rel_we", rf_we, 0);
    check_eq("rel_done", done, 0);

    // Directed cases.
    run_instr(r_type(7'h00, 5'd2, 5'd1, 3'd0, 5'd3));
    check_eq("add_x3", reg_m[3], 32'd12);
    run_instr(r_type(7'h20, 5'd2, 5'd1, 3'd0, 5'd4));
    check_eq("sub_x4", reg_m[4], 32'hFFFF_FFFE);
    reg_m[1] = 32'h8000_0000;
    run_instr(i_type(12'h404, 5'd1, 3'd5, 5'd5));
    check_eq("srai_x5", reg_m[5], 32'hF800_0000);
    run_instr(i_type(12'h001, 5'd1, 3'd0, 5'd0));
    reg_m[1] = 32'd3;
    run_instr(i_type(12'hFFF, 5'd1, 3'd3, 5'd6));
    check_eq("sltiu_x6", reg_m[6], 32'd1);
    run_instr(32'h0000_12B7);
    run_instr(r_type(7'h20, 5'd2, 5'd1, 3'd7, 5'd7));

    // Randomized mix of legal, near-legal and garbage words.
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: begin
          case ($urandom_range(0, 4))
            0, 1:    rnd_f7 = 7'h00;
            2, 3:    rnd_f7 = 7'h20;
            default: rnd_f7 = 7'($urandom);
          endcase
          rnd_ins = r_type(rnd_f7, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom));
        end
        4, 5, 6, 7: begin
          rnd_ins = i_type(12'($urandom), 5'($urandom), 3'($urandom), 5'($urandom));
          if ($urandom_range(0, 3) != 0) rnd_ins[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
        end
        8: rnd_ins = $urandom;
        default: begin
          rnd_ins      = r_type(7'h00, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom));
          rnd_ins[1:0] = 2'($urandom_range(0, 2));
        end
      endcase
      run_instr(rnd_ins);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
